// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: datapath width, load funct3
// encodings, stage FSM states and the stage-register entry layout.
package wb_stage_pkg;

    localparam int WB_XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0] pc;
        logic [31:0]        inst;
        logic               rd_we;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] result;
        logic               is_load;
        logic [2:0]         funct3;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: shifts the doubleword down to the byte offset,
// truncates to the access size and sign- or zero-extends.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] wdata
);

    logic [63:0] shifted;
    logic        sx;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        // funct3[2] selects the unsigned variants; funct3=111 falls into the ld arm
        sx      = ~funct3[2];
        wdata   = shifted;
        case (funct3[1:0])
            2'b00:   wdata = {{56{sx & shifted[7]}},  shifted[7:0]};
            2'b01:   wdata = {{48{sx & shifted[15]}}, shifted[15:0]};
            2'b10:   wdata = {{32{sx & shifted[31]}}, shifted[31:0]};
            default: wdata = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry stage register, load formatting, register-file
// write port and retired-instruction counter. WB_TRACE_EN adds commit-trace ports.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [31:0]     mem_inst,
    input  logic            mem_rd_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [63:0]     instret
`ifdef WB_TRACE_EN
    ,
    output logic            trace_valid,
    output logic [XLEN-1:0] trace_pc,
    output logic [31:0]     trace_inst,
    output logic [4:0]      trace_rd,
    output logic            trace_wen,
    output logic [XLEN-1:0] trace_wdata
`endif
);

    wb_state_e   state_q, state_d;
    wb_entry_t   entry_q, entry_d;
    logic [63:0] instret_q, instret_d;
    logic        commit;
    logic        accept;
    logic [63:0] load_data;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (entry_q.result[2:0]),
        .funct3 (entry_q.funct3),
        .wdata  (load_data)
    );

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        // a held load waits for dmem_rvalid; rvalid is ignored otherwise
        commit    = (state_q == ST_FULL) & (~entry_q.is_load | dmem_rvalid);
        mem_ready = (state_q == ST_EMPTY) | commit;
        accept    = mem_valid & mem_ready;
        instret_d = instret_q + {63'd0, commit};

        if (accept) begin
            state_d         = ST_FULL;
            entry_d.pc      = mem_pc;
            entry_d.inst    = mem_inst;
            entry_d.rd_we   = mem_rd_we;
            entry_d.rd      = mem_rd;
            entry_d.result  = mem_result;
            entry_d.is_load = mem_is_load;
            entry_d.funct3  = mem_funct3;
        end else if (commit) begin
            state_d = ST_EMPTY;
        end

        rf_we    = commit & entry_q.rd_we & (entry_q.rd != 5'd0);
        rf_waddr = entry_q.rd;
        rf_wdata = entry_q.is_load ? load_data : entry_q.result;
        instret  = instret_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            entry_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            instret_q <= instret_d;
        end
    end

`ifdef WB_TRACE_EN
    assign trace_valid = commit;
    assign trace_pc    = entry_q.pc;
    assign trace_inst  = entry_q.inst;
    assign trace_rd    = entry_q.rd;
    assign trace_wen   = rf_we;
    assign trace_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, non-load and load writeback, load
// formatting, x0 suppression, back-to-back throughput and reset mid-load.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_pc;
    logic [31:0] mem_inst;
    logic        mem_rd_we;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] instret;

    int          n_checks;
    int          n_pass;
    logic [63:0] exp_instret;
    logic [63:0] exp_q[$];

    wb_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_pc      (mem_pc),
        .mem_inst    (mem_inst),
        .mem_rd_we   (mem_rd_we),
        .mem_rd      (mem_rd),
        .mem_result  (mem_result),
        .mem_is_load (mem_is_load),
        .mem_funct3  (mem_funct3),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_valid   = 1'b0;
        mem_pc      = '0;
        mem_inst    = '0;
        mem_rd_we   = 1'b0;
        mem_rd      = '0;
        mem_result  = '0;
        mem_is_load = 1'b0;
        mem_funct3  = '0;
    endtask

    task automatic present(input logic [4:0] rd, input logic rd_we, input logic [63:0] result,
                           input logic is_load, input logic [2:0] f3);
        mem_valid   = 1'b1;
        mem_pc      = 64'h8000_0000 + {59'd0, rd} * 4;
        mem_inst    = 32'h0000_0013 | {20'd0, rd, 7'd0};
        mem_rd_we   = rd_we;
        mem_rd      = rd;
        mem_result  = result;
        mem_is_load = is_load;
        mem_funct3  = f3;
    endtask

    // present for one edge, then idle the MEM side
    task automatic send(input logic [4:0] rd, input logic rd_we, input logic [63:0] result,
                        input logic is_load, input logic [2:0] f3);
        present(rd, rd_we, result, is_load, f3);
        tick();
        drive_idle();
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        drive_idle();
        tick();
        tick();
        rst_n       = 1'b1;
        exp_instret = 64'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL reset_rf_we actual=%0b required=0", rf_we);
        else n_pass++;
        n_checks++;
        if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready actual=%0b required=1", mem_ready);
        else n_pass++;
        n_checks++;
        if (rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr actual=%0d required=0", rf_waddr);
        else n_pass++;
        n_checks++;
        if (rf_wdata !== 64'd0) $display("FAIL reset_rf_wdata actual=%h required=0", rf_wdata);
        else n_pass++;
        n_checks++;
        if (instret !== 64'd0) $display("FAIL reset_instret actual=%0d required=0", instret);
        else n_pass++;
    endtask

    task automatic test_nonload();
        send(5'd5, 1'b1, 64'h1234, 1'b0, 3'b000);
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234)
            $display("FAIL nonload_write actual=%0b/%0d/%h required=1/5/1234", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL nonload_instret_pre actual=%0d required=%0d", instret, exp_instret);
        else n_pass++;
        tick();
        exp_instret++;
        n_checks++;
        if (instret !== exp_instret || rf_we !== 1'b0)
            $display("FAIL nonload_instret_post actual=%0d/%0b required=%0d/0", instret, rf_we, exp_instret);
        else n_pass++;
    endtask

    task automatic test_load_stall();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 64'h0000_0000_8000_0000;
        send(5'd9, 1'b1, 64'h0000_1000_0000_0003, 1'b1, 3'b000);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (mem_ready !== 1'b0 || rf_we !== 1'b0)
                $display("FAIL load_stall_c%0d actual=%0b/%0b required=0/0", c, mem_ready, rf_we);
            else n_pass++;
            if (c == 0) tick();
        end
        dmem_rvalid = 1'b1;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80 || mem_ready !== 1'b1)
            $display("FAIL load_lb_commit actual=%0b/%0d/%h/%0b required=1/9/ffffffffffffff80/1",
                     rf_we, rf_waddr, rf_wdata, mem_ready);
        else n_pass++;
        tick();
        dmem_rvalid = 1'b0;
        exp_instret++;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || instret !== exp_instret)
            $display("FAIL load_lb_after actual=%0b/%0d required=0/%0d", rf_we, instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3_t[6];
        logic [2:0]  off_t[6];
        logic [63:0] rdata_t[6];
        logic [63:0] exp_t[6];
        f3_t[0] = 3'b110; off_t[0] = 3'd4; rdata_t[0] = 64'hDEAD_BEEF_0000_0000; exp_t[0] = 64'h0000_0000_DEAD_BEEF;
        f3_t[1] = 3'b001; off_t[1] = 3'd6; rdata_t[1] = 64'hDEAD_BEEF_0000_0000; exp_t[1] = 64'hFFFF_FFFF_FFFF_DEAD;
        f3_t[2] = 3'b011; off_t[2] = 3'd0; rdata_t[2] = 64'h0123_4567_89AB_CDEF; exp_t[2] = 64'h0123_4567_89AB_CDEF;
        f3_t[3] = 3'b100; off_t[3] = 3'd7; rdata_t[3] = 64'h8011_2233_4455_6677; exp_t[3] = 64'h0000_0000_0000_0080;
        f3_t[4] = 3'b111; off_t[4] = 3'd0; rdata_t[4] = 64'hFEDC_BA98_7654_3210; exp_t[4] = 64'hFEDC_BA98_7654_3210;
        f3_t[5] = 3'b010; off_t[5] = 3'd0; rdata_t[5] = 64'h0000_0000_8000_0001; exp_t[5] = 64'hFFFF_FFFF_8000_0001;
        for (int i = 0; i < 6; i++) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata_t[i];
            send(5'd10 + 5'(i), 1'b1, {61'h0ABC, off_t[i]}, 1'b1, f3_t[i]);
            n_checks++;
            if (rf_we !== 1'b1 || rf_wdata !== exp_t[i])
                $display("FAIL load_fmt_%0d actual=%0b/%h required=1/%h", i, rf_we, rf_wdata, exp_t[i]);
            else n_pass++;
            tick();
            exp_instret++;
        end
        dmem_rvalid = 1'b0;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL load_fmt_instret actual=%0d required=%0d", instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_rd_zero();
        send(5'd0, 1'b1, 64'hFF, 1'b0, 3'b000);
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL rd0_rf_we actual=%0b required=0", rf_we);
        else n_pass++;
        tick();
        exp_instret++;
        send(5'd7, 1'b0, 64'h77, 1'b0, 3'b000);
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL rdwe0_rf_we actual=%0b required=0", rf_we);
        else n_pass++;
        tick();
        exp_instret++;
        n_checks++;
        if (instret !== exp_instret) $display("FAIL rd0_instret actual=%0d required=%0d", instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_w;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(64'h1000 + 64'(i) * 64'h11);
            n_checks++;
            if (mem_ready !== 1'b1) $display("FAIL b2b_ready_%0d actual=%0b required=1", i, mem_ready);
            else n_pass++;
            present(5'd20 + 5'(i), 1'b1, 64'h1000 + 64'(i) * 64'h11, 1'b0, 3'b000);
            tick();
            exp_w = exp_q.pop_front();
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd20 + 5'(i) || rf_wdata !== exp_w)
                $display("FAIL b2b_write_%0d actual=%0b/%0d/%h required=1/%0d/%h",
                         i, rf_we, rf_waddr, rf_wdata, 5'd20 + 5'(i), exp_w);
            else n_pass++;
        end
        drive_idle();
        tick();
        n_checks++;
        if (instret !== 64'd4) $display("FAIL b2b_instret actual=%0d required=4", instret);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 64'h1122_3344_5566_7788;
        send(5'd3, 1'b1, 64'h0, 1'b1, 3'b011);
        n_checks++;
        if (mem_ready !== 1'b0) $display("FAIL rstload_hold actual=%0b required=0", mem_ready);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (rf_we !== 1'b0 || instret !== 64'd0 || mem_ready !== 1'b1)
            $display("FAIL rstload_after actual=%0b/%0d/%0b required=0/0/1", rf_we, instret, mem_ready);
        else n_pass++;
        dmem_rvalid = 1'b1;
        #1;
        n_checks++;
        if (rf_we !== 1'b0) $display("FAIL rstload_rvalid_we actual=%0b required=0", rf_we);
        else n_pass++;
        tick();
        dmem_rvalid = 1'b0;
        n_checks++;
        if (instret !== 64'd0) $display("FAIL rstload_rvalid_instret actual=%0d required=0", instret);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_nonload();
        test_load_stall();
        test_load_formats();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
